// File: rtl/stream_mux_rr.sv
// N-input registered stream multiplexer with valid/ready handshakes, fixed-select
// or round-robin arbitration, and grant held for a whole packet delimited by last.
module stream_mux_rr #(
  parameter int WIDTH = 64,
  parameter int N     = 4,
  parameter int MODE  = 0,
  localparam int SW   = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  input  logic [N-1:0]       in_last,
  output logic [N-1:0]       in_ready,
  input  logic [SW-1:0]      sel,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  output logic               out_last,
  output logic [SW-1:0]      out_src,
  input  logic               out_ready
);

  logic             r_lock;
  logic [SW-1:0]    r_lock_idx;
  logic [SW-1:0]    r_ptr;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_out_last;
  logic [SW-1:0]    r_out_src;

  logic             w_load_en;
  logic             w_has_cand;
  logic [SW-1:0]    w_g;
  logic [SW-1:0]    w_g_inc;
  logic [WIDTH-1:0] w_cand_data;
  logic             w_cand_valid;
  logic             w_cand_last;
  logic             w_accept;
  int               w_best;
  int               w_dist;

  assign w_load_en = !r_out_valid || out_ready;

  // Candidate selection: lock wins, then sel (MODE 0) or nearest valid from ptr (MODE 1).
  always_comb begin
    w_has_cand = 1'b0;
    w_g        = '0;
    w_best     = N;
    w_dist     = 0;
    if (r_lock) begin
      w_has_cand = 1'b1;
      w_g        = r_lock_idx;
    end else if (MODE == 0) begin
      w_has_cand = (int'(sel) < N);
      w_g        = sel;
    end else begin
      for (int i = 0; i < N; i++) begin
        w_dist = (i + N - int'(r_ptr)) % N;
        if (in_valid[i] && (w_dist < w_best)) begin
          w_best     = w_dist;
          w_has_cand = 1'b1;
          w_g        = SW'(i);
        end
      end
    end
  end

  always_comb begin
    w_cand_data  = '0;
    w_cand_valid = 1'b0;
    w_cand_last  = 1'b0;
    in_ready     = '0;
    for (int i = 0; i < N; i++) begin
      if (w_has_cand && (w_g == SW'(i))) begin
        w_cand_data  = in_data[i*WIDTH +: WIDTH];
        w_cand_valid = in_valid[i];
        w_cand_last  = in_last[i];
        in_ready[i]  = w_load_en && !reset;
      end
    end
  end

  assign w_accept = w_cand_valid && w_load_en && !reset;
  assign w_g_inc  = (int'(w_g) == N - 1) ? '0 : w_g + SW'(1);

  // Output register stage and packet lock / round-robin pointer state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock      <= 1'b0;
      r_lock_idx  <= '0;
      r_ptr       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_src   <= '0;
    end else if (w_load_en) begin
      if (w_accept) begin
        r_out_data  <= w_cand_data;
        r_out_valid <= 1'b1;
        r_out_last  <= w_cand_last;
        r_out_src   <= w_g;
        if (w_cand_last) begin
          r_lock <= 1'b0;
          if (MODE != 0) r_ptr <= w_g_inc;
        end else begin
          r_lock     <= 1'b1;
          r_lock_idx <= w_g;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_src   = r_out_src;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: directed scenarios on fixed-select, round-robin and
// 3-input variants, then randomized traffic against a transaction-level model.
module tb_stream_mux_rr;
  localparam int W = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [4*W-1:0] a_data;
  logic [3:0]     a_valid, a_last;
  logic [1:0]     a_sel;
  logic           a_ordy;
  logic [3:0]     r0_ready, r1_ready;
  logic [W-1:0]   d0, d1;
  logic           v0, v1, l0, l1;
  logic [1:0]     s0, s1;

  logic [3*W-1:0] c_data;
  logic [2:0]     c_valid, c_last, c_ready;
  logic [1:0]     c_sel, c_src;
  logic           c_ordy, c_ov, c_ol;
  logic [W-1:0]   c_dout;

  int checks = 0;
  int errors = 0;

  stream_mux_rr #(.WIDTH(W), .N(4), .MODE(0)) u_m0 (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .in_ready(r0_ready), .sel(a_sel), .out_data(d0), .out_valid(v0), .out_last(l0),
    .out_src(s0), .out_ready(a_ordy));

  stream_mux_rr #(.WIDTH(W), .N(4), .MODE(1)) u_m1 (
    .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
    .in_ready(r1_ready), .sel(a_sel), .out_data(d1), .out_valid(v1), .out_last(l1),
    .out_src(s1), .out_ready(a_ordy));

  stream_mux_rr #(.WIDTH(W), .N(3), .MODE(0)) u_m3 (
    .clk(clk), .reset(reset), .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
    .in_ready(c_ready), .sel(c_sel), .out_data(c_dout), .out_valid(c_ov), .out_last(c_ol),
    .out_src(c_src), .out_ready(c_ordy));

  // Transaction-level reference: lock = -1 means no packet in progress.
  typedef struct packed {
    int           lock;
    int           ptr;
    logic         ov;
    logic [W-1:0] od;
    logic         ol;
    int           os;
  } mst_t;

  function automatic mst_t m_rst();
    mst_t r;
    r.lock = -1; r.ptr = 0; r.ov = 1'b0; r.od = '0; r.ol = 1'b0; r.os = 0;
    return r;
  endfunction

  function automatic int m_cand(mst_t s, int mode, int n, int sl, logic [3:0] v);
    if (s.lock >= 0) return s.lock;
    if (mode == 0) return (sl < n) ? sl : -1;
    for (int k = 0; k < n; k++)
      if (v[(s.ptr + k) % n]) return (s.ptr + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] m_ready(mst_t s, int mode, int n, int sl, logic [3:0] v,
                                         logic ordy);
    int g = m_cand(s, mode, n, sl, v);
    if ((!s.ov || ordy) && g >= 0) return 4'(1 << g);
    return 4'b0;
  endfunction

  function automatic mst_t m_step(mst_t s, int mode, int n, int sl, logic [3:0] v,
                                  logic [3:0] l, logic [4*W-1:0] d, logic ordy);
    mst_t r = s;
    int g = m_cand(s, mode, n, sl, v);
    if (s.ov && !ordy) return r;
    if (g >= 0 && v[g]) begin
      r.ov = 1'b1; r.od = d[g*W +: W]; r.ol = l[g]; r.os = g;
      if (l[g]) begin
        r.lock = -1;
        if (mode == 1) r.ptr = (g + 1) % n;
      end else begin
        r.lock = g;
      end
    end else begin
      r.ov = 1'b0;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; a_valid = '0; c_valid = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; a_valid = 4'hF; a_last = 4'hF; a_sel = 2'd2; a_ordy = 1'b1;
    c_valid = 3'h7; c_last = 3'h7; c_sel = 2'd0; c_ordy = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({v0, l0, s0, d0} !== '0) begin
      errors++; $display("FAIL reset_out_m0 got %b_%b_%h_%h exp all zero", v0, l0, s0, d0);
    end
    checks++;
    if ({v1, l1, s1, d1, c_ov, c_dout} !== '0) begin
      errors++; $display("FAIL reset_out_m1_m3 got %b %h %b %h exp zero", v1, d1, c_ov, c_dout);
    end
    checks++;
    if ({r0_ready, r1_ready, c_ready} !== '0) begin
      errors++; $display("FAIL reset_ready got %b %b %b exp 0", r0_ready, r1_ready, c_ready);
    end
    tick();
    reset = 1'b0; a_valid = '0; c_valid = '0;
    tick();
  endtask

  task automatic test_fixed_select();
    a_sel = 2'd2; a_valid = 4'hF; a_last = 4'hF; a_ordy = 1'b1;
    a_data = {16'h0013, 16'h00A5, 16'h0011, 16'h0010};
    @(negedge clk);
    checks++;
    if (r0_ready !== 4'b0100) begin
      errors++; $display("FAIL fixed_ready got %b exp 0100", r0_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({v0, s0, d0} !== {1'b1, 2'd2, 16'h00A5}) begin
      errors++; $display("FAIL fixed_out got v=%b src=%0d data=%h exp v=1 src=2 data=00a5", v0, s0, d0);
    end
    a_valid = '0;
    tick(); tick();
  endtask

  task automatic test_lock();
    a_sel = 2'd1; a_valid = 4'b1010; a_last = 4'b1000; a_ordy = 1'b1;
    a_data = {16'h0333, 16'h0000, 16'h00D0, 16'h0000};
    @(negedge clk);
    checks++;
    if (r0_ready !== 4'b0010) begin
      errors++; $display("FAIL lock_ready0 got %b exp 0010", r0_ready);
    end
    tick();
    a_sel = 2'd3; a_data[W +: W] = 16'h00D1;
    @(negedge clk);
    checks++;
    if ({v0, l0, s0, d0, r0_ready} !== {1'b1, 1'b0, 2'd1, 16'h00D0, 4'b0010}) begin
      errors++; $display("FAIL lock_beat0 got %b %b %0d %h %b exp 1 0 1 00d0 0010", v0, l0, s0, d0, r0_ready);
    end
    tick();
    a_data[W +: W] = 16'h00D2; a_last = 4'b1010;
    @(negedge clk);
    checks++;
    if ({v0, l0, s0, d0, r0_ready} !== {1'b1, 1'b0, 2'd1, 16'h00D1, 4'b0010}) begin
      errors++; $display("FAIL lock_beat1 got %b %b %0d %h %b exp 1 0 1 00d1 0010", v0, l0, s0, d0, r0_ready);
    end
    tick();
    a_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if ({v0, l0, s0, d0, r0_ready} !== {1'b1, 1'b1, 2'd1, 16'h00D2, 4'b1000}) begin
      errors++; $display("FAIL lock_beat2 got %b %b %0d %h %b exp 1 1 1 00d2 1000", v0, l0, s0, d0, r0_ready);
    end
    tick();
    a_valid = '0;
    @(negedge clk);
    checks++;
    if ({v0, l0, s0, d0} !== {1'b1, 1'b1, 2'd3, 16'h0333}) begin
      errors++; $display("FAIL lock_next got %b %b %0d %h exp 1 1 3 0333", v0, l0, s0, d0);
    end
    tick();
  endtask

  task automatic test_rr_fairness();
    do_reset();
    a_valid = 4'hF; a_last = 4'hF; a_ordy = 1'b1;
    a_data = {16'h0103, 16'h0102, 16'h0101, 16'h0100};
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k < 6) begin
        checks++;
        if (r1_ready !== 4'(1 << (k % 4))) begin
          errors++; $display("FAIL rr_ready_%0d got %b exp %b", k, r1_ready, 4'(1 << (k % 4)));
        end
      end
      if (k > 0) begin
        checks++;
        if ({v1, s1, d1} !== {1'b1, 2'((k - 1) % 4), 16'(16'h0100 + (k - 1) % 4)}) begin
          errors++; $display("FAIL rr_src_%0d got v=%b src=%0d data=%h exp src=%0d", k, v1, s1, d1, (k - 1) % 4);
        end
      end
      if (k == 6) a_valid = '0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    a_valid = 4'b0001; a_last = 4'hF; a_ordy = 1'b1; a_data = '0; a_data[0 +: W] = 16'h00B0;
    tick();
    a_data[0 +: W] = 16'h00B1; a_ordy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      checks++;
      if ({v1, d1, r1_ready} !== {1'b1, 16'h00B0, 4'b0000}) begin
        errors++; $display("FAIL bp_stall_%0d got v=%b data=%h ready=%b exp 1 00b0 0000", j, v1, d1, r1_ready);
      end
      tick();
    end
    a_ordy = 1'b1;
    @(negedge clk);
    checks++;
    if ({d1, r1_ready} !== {16'h00B0, 4'b0001}) begin
      errors++; $display("FAIL bp_release got data=%h ready=%b exp 00b0 0001", d1, r1_ready);
    end
    tick();
    a_valid = '0;
    @(negedge clk);
    checks++;
    if ({v1, d1} !== {1'b1, 16'h00B1}) begin
      errors++; $display("FAIL bp_next got v=%b data=%h exp 1 00b1", v1, d1);
    end
    tick();
    @(negedge clk);
    checks++;
    if (v1 !== 1'b0) begin
      errors++; $display("FAIL bp_drain got v=%b exp 0", v1);
    end
    tick();
  endtask

  task automatic test_reset_mid_packet();
    // ptr is 1 after the two channel-0 beats of the previous test, so channel 2 wins.
    a_valid = 4'b0101; a_last = 4'b0000; a_ordy = 1'b1;
    a_data = {16'h0000, 16'h00C0, 16'h0000, 16'h00EE};
    @(negedge clk);
    checks++;
    if (r1_ready !== 4'b0100) begin
      errors++; $display("FAIL mid_ready0 got %b exp 0100", r1_ready);
    end
    tick();
    a_data[2*W +: W] = 16'h00C1;
    @(negedge clk);
    checks++;
    if ({s1, d1, r1_ready} !== {2'd2, 16'h00C0, 4'b0100}) begin
      errors++; $display("FAIL mid_beat0 got src=%0d data=%h ready=%b exp 2 00c0 0100", s1, d1, r1_ready);
    end
    tick();
    reset = 1'b1; a_data[2*W +: W] = 16'h00C2;
    @(negedge clk);
    checks++;
    if (r1_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_ready_in_reset got %b exp 0000", r1_ready);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({v1, r1_ready} !== {1'b0, 4'b0001}) begin
      errors++; $display("FAIL mid_after_reset got v=%b ready=%b exp 0 0001", v1, r1_ready);
    end
    tick();
    a_valid = '0; a_last = 4'hF;
    @(negedge clk);
    checks++;
    if ({v1, s1, d1} !== {1'b1, 2'd0, 16'h00EE}) begin
      errors++; $display("FAIL mid_first_grant got v=%b src=%0d data=%h exp 1 0 00ee", v1, s1, d1);
    end
    tick();
  endtask

  task automatic test_out_of_range();
    c_sel = 2'd0; c_valid = 3'h7; c_last = 3'h7; c_ordy = 1'b1;
    c_data = {16'h0032, 16'h0031, 16'h0030};
    tick();
    c_sel = 2'd3; c_ordy = 1'b0;
    @(negedge clk);
    checks++;
    if ({c_ready, c_ov} !== {3'b000, 1'b1}) begin
      errors++; $display("FAIL oor_stall got ready=%b v=%b exp 000 1", c_ready, c_ov);
    end
    tick();
    c_ordy = 1'b1;
    @(negedge clk);
    checks++;
    if ({c_ready, c_ov} !== {3'b000, 1'b1}) begin
      errors++; $display("FAIL oor_release got ready=%b v=%b exp 000 1", c_ready, c_ov);
    end
    tick();
    @(negedge clk);
    checks++;
    if ({c_ready, c_ov, c_dout} !== {3'b000, 1'b0, 16'h0030}) begin
      errors++; $display("FAIL oor_drained got ready=%b v=%b data=%h exp 000 0 0030", c_ready, c_ov, c_dout);
    end
    c_valid = '0;
    tick();
  endtask

  task automatic test_random();
    mst_t       m0, m1;
    logic [3:0] e0, e1;
    reset = 1'b1;
    tick();
    m0 = m_rst(); m1 = m_rst();
    for (int t = 0; t < 3000; t++) begin
      reset   = ($urandom_range(0, 63) == 0);
      a_valid = 4'($urandom_range(0, 15));
      a_last  = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      a_data  = {$urandom, $urandom};
      a_sel   = 2'($urandom_range(0, 3));
      a_ordy  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      e0 = reset ? 4'b0 : m_ready(m0, 0, 4, int'(a_sel), a_valid, a_ordy);
      e1 = reset ? 4'b0 : m_ready(m1, 1, 4, int'(a_sel), a_valid, a_ordy);
      checks++;
      if ({r0_ready, v0, l0, s0, d0} !== {e0, m0.ov, m0.ol, 2'(m0.os), m0.od}) begin
        errors++;
        $display("FAIL rand_m0 t=%0d got rdy=%b v=%b l=%b src=%0d d=%h exp rdy=%b v=%b l=%b src=%0d d=%h",
                 t, r0_ready, v0, l0, s0, d0, e0, m0.ov, m0.ol, m0.os, m0.od);
      end
      checks++;
      if ({r1_ready, v1, l1, s1, d1} !== {e1, m1.ov, m1.ol, 2'(m1.os), m1.od}) begin
        errors++;
        $display("FAIL rand_m1 t=%0d got rdy=%b v=%b l=%b src=%0d d=%h exp rdy=%b v=%b l=%b src=%0d d=%h",
                 t, r1_ready, v1, l1, s1, d1, e1, m1.ov, m1.ol, m1.os, m1.od);
      end
      if (reset) begin
        m0 = m_rst(); m1 = m_rst();
      end else begin
        m0 = m_step(m0, 0, 4, int'(a_sel), a_valid, a_last, a_data, a_ordy);
        m1 = m_step(m1, 1, 4, int'(a_sel), a_valid, a_last, a_data, a_ordy);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0; a_valid = '0;
  endtask

  initial begin
    reset = 1'b1; a_data = '0; a_valid = '0; a_last = '0; a_sel = '0; a_ordy = 1'b0;
    c_data = '0; c_valid = '0; c_last = '0; c_sel = '0; c_ordy = 1'b0;
    test_reset();
    test_fixed_select();
    test_lock();
    test_rr_fairness();
    test_back_pressure();
    test_reset_mid_packet();
    test_out_of_range();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-input, WIDTH-bit registered stream multiplexer with valid/ready handshakes on every port. It supports a fixed-select mode and a round-robin arbitration mode. It holds its grant for a whole multi-beat packet, delimited by `last`. It sits between datapath producers (ALU, load unit, forwarding sources) and a single downstream consumer. It replaces the ad-hoc 2:1 64-bit selectors where back-pressure or fair sharing is needed.

## Interface
Parameters:
- `WIDTH`, default 64: data width per channel.
- `N`, default 4: input channel count, N ≥ 2. `SW = $clog2(N)`.
- `MODE`, default 0: 0 = fixed select from `sel`; 1 = round-robin arbitration, `sel` ignored.

Ports:
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_data`  in  N*WIDTH: channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  in  N: per-channel valid.
- `in_last`  in  N: per-channel end-of-packet flag, qualified by `in_valid`.
- `in_ready`  out  N: per-channel ready, one-hot or zero.
- `sel`  in  SW: channel select, MODE 0 only.
- `out_data`  out  WIDTH: registered data.
- `out_valid`  out  1: registered valid.
- `out_last`  out  1: registered last.
- `out_src`  out  SW: index of the channel that produced the current output beat.
- `out_ready`  in  1: downstream ready.

## Operation
- Single output register. `load_en = !out_valid || out_ready`.
- Candidate channel `g`:
  - Locked: `g` = lock index, regardless of `sel` or other valids.
  - Unlocked, MODE 0: `g = sel`. If `sel ≥ N`, there is no candidate.
  - Unlocked, MODE 1: `g` is the first i with `in_valid[i]`, scanning ptr, ptr+1, … wrapping mod N. If no input is valid, there is no candidate.
- `in_ready[g] = load_en` when a candidate exists; all other bits are 0. In MODE 1, `in_ready` depends combinationally on `in_valid`. No other combinational paths exist from inputs to outputs except to `in_ready`.
- Accept = `in_valid[g] && in_ready[g]`. On accept:
  - `out_data <= in_data[g]`, `out_valid <= 1`, `out_last <= in_last[g]`, `out_src <= g`.
  - If `in_last[g]`: clear lock. In MODE 1, `ptr <= (g+1) mod N`.
  - Else: set lock to `g`.
- `load_en` without accept: `out_valid <= 0`. `out_data`, `out_last` and `out_src` hold their values.
- `!load_en` (stalled): all output registers hold. `in_ready` is all zero.
- `ptr` advances only at end of packet, never on idle cycles or on non-last beats.
- MODE 0: a change of `sel` mid-packet has no effect until the locked packet's last beat is accepted.
- Single-beat packets (`in_last` = 1 on the first beat) never set the lock.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 beat/cycle sustained while `out_ready` = 1.
- Arbitration across packets: no bubble. The next packet's first beat may be accepted in the cycle after the previous packet's last beat.
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0, `out_src` = 0.
  - `ptr` = 0, lock cleared.
  - `in_ready` = 0 during reset.
- Reset mid-packet: lock and any buffered beat are discarded. The first cycle after reset deasserts behaves as unlocked with ptr = 0.
- Simultaneous `out_ready` and accept in the same cycle: the old beat leaves and the new beat loads. `out_valid` stays 1.
- Wrap-around: in MODE 1 with g = N−1 and last accepted, `ptr` becomes 0.

## Test plan
- **MODE 0, N=4:** set `sel` = 2, `in_valid` = 4'b1111, single-beat packets, `in_data[2]` = 0xA5, `out_ready` = 1. Required: `out_data` = 0xA5 and `out_src` = 2 one cycle later. Only `in_ready[2]` is high.
- **MODE 0 lock:** send a 3-beat packet on channel 1 (D0, D1, D2), changing `sel` to 3 after beat 0. Required: `out_src` = 1 for all three beats and `out_last` = 1 on D2 only. Channel 3 is accepted in the cycle after D2 is accepted.
- **MODE 1 fairness:** all 4 channels continuously valid with single-beat packets, `out_ready` = 1. Required: `out_src` sequence is 0,1,2,3,0,1. `ptr` wraps from 3 to 0.
- **Back-pressure:** hold `out_ready` = 0 for 3 cycles while `out_valid` = 1. Required: `out_data` is stable and `in_ready` = 0. When `out_ready` returns to 1, the held beat and the next beat transfer in consecutive cycles with no loss or duplication.
- **Reset mid-packet:** in MODE 1, assert `reset` after beat 1 of a 4-beat packet on channel 2, with channel 0 also valid. Required: `out_valid` = 0 the next cycle. After reset, channel 0 is granted first (ptr = 0, unlocked).
- **MODE 0 out-of-range select:** N=3, `sel` = 3, all inputs valid. Required: `in_ready` = 0 and `out_valid` falls to 0 once the last buffered beat drains.
